exec_muldiv_unit: RTL and testbench

//  Iterative 16-bit multiply/divide unit in the execute stage. Reads the operand fields that the

---
 rtl/muldiv_pkg.sv | 20 ++
 rtl/exec_muldiv_unit.sv | 163 ++++++++++++++++
 tb/tb_exec_muldiv_unit.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// Shared encodings and constants for the iterative multiply/divide unit.
// Optional two's-complement support is enabled by the MULDIV_SIGNED_EN macro.
package muldiv_pkg;

    localparam int unsigned MD_WIDTH = 16;

    localparam logic [1:0] OP_MULU = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_MULS = 2'b10;
    localparam logic [1:0] OP_DIVS = 2'b11;

    localparam logic [15:0] DIV0_QUOT = 16'hFFFF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } md_state_e;

endpackage

// File: rtl/exec_muldiv_unit.sv
// Execute-stage radix-2 multiply / restoring divide unit, one iteration per cycle.
// Define MULDIV_SIGNED_EN to make MULS/DIVS two's-complement; otherwise op[1] is ignored.
module exec_muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = MD_WIDTH,
    parameter int unsigned CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rd_data,
    input  logic [2:0]       rd,
    input  logic             flush,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi,
    output logic [2:0]       rd_out,
    output logic             div_zero
);

    localparam int unsigned AW = 2*WIDTH + 1;

    md_state_e        state;
    logic [CNT_W-1:0] count;
    logic [AW-1:0]    acc;
    logic [AW-1:0]    acc_nxt;
    logic [WIDTH-1:0] opnd;
    logic             is_div;
    logic             dz;
    logic [2:0]       rd_q;

    logic             start_dz;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH:0]   add_sum;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] fin_lo;
    logic [WIDTH-1:0] fin_hi;

    assign stall    = (state == ST_BUSY) | (start & (state != ST_BUSY));
    assign start_dz = op[0] & (rd_data == '0);

`ifdef MULDIV_SIGNED_EN
    logic neg_prod;
    logic neg_quo;
    logic neg_rem;

    always_comb begin
        a_mag = rs_data;
        b_mag = rd_data;
        if (op[1]) begin
            if (rs_data[WIDTH-1]) a_mag = -rs_data;
            if (rd_data[WIDTH-1]) b_mag = -rd_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            neg_prod <= 1'b0;
            neg_quo  <= 1'b0;
            neg_rem  <= 1'b0;
        end else if (start && !flush && state != ST_BUSY) begin
            neg_prod <= op[1] & ~op[0] & (rs_data[WIDTH-1] ^ rd_data[WIDTH-1]);
            neg_quo  <= op[1] &  op[0] & (rs_data[WIDTH-1] ^ rd_data[WIDTH-1]);
            neg_rem  <= op[1] &  op[0] &  rs_data[WIDTH-1];
        end
    end
`else
    logic unused_op_sign;
    assign unused_op_sign = op[1];
    assign a_mag = rs_data;
    assign b_mag = rd_data;
`endif

    // acc holds {carry, hi, lo}: product/multiplier for MUL, remainder/quotient for DIV.
    always_comb begin
        add_sum = acc[AW-1:WIDTH] + (acc[0] ? {1'b0, opnd} : '0);
        rem_sh  = acc[2*WIDTH-1:WIDTH-1];
        diff    = rem_sh - {1'b0, opnd};
        if (!is_div)
            acc_nxt = {1'b0, add_sum, acc[WIDTH-1:1]};
        else if (rem_sh >= {1'b0, opnd})
            acc_nxt = {diff, acc[WIDTH-2:0], 1'b1};
        else
            acc_nxt = {rem_sh, acc[WIDTH-2:0], 1'b0};
    end

    always_comb begin
        fin_lo = acc_nxt[WIDTH-1:0];
        fin_hi = acc_nxt[2*WIDTH-1:WIDTH];
`ifdef MULDIV_SIGNED_EN
        if (neg_prod) {fin_hi, fin_lo} = -acc_nxt[2*WIDTH-1:0];
        if (neg_quo)  fin_lo = -acc_nxt[WIDTH-1:0];
        if (neg_rem)  fin_hi = -acc_nxt[2*WIDTH-1:WIDTH];
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            count     <= '0;
            done      <= 1'b0;
            div_zero  <= 1'b0;
            result_lo <= '0;
            result_hi <= '0;
            rd_out    <= '0;
            acc       <= '0;
            opnd      <= '0;
            is_div    <= 1'b0;
            dz        <= 1'b0;
            rd_q      <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                ST_IDLE, ST_DONE: begin
                    if (start && !flush) begin
                        // divide-by-zero keeps the raw dividend for result_hi
                        acc    <= {{(AW-WIDTH){1'b0}}, start_dz ? rs_data : a_mag};
                        opnd   <= b_mag;
                        is_div <= op[0];
                        dz     <= start_dz;
                        rd_q   <= rd;
                        count  <= '0;
                        state  <= ST_BUSY;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_BUSY: begin
                    if (flush) begin
                        state <= ST_IDLE;
                    end else if (dz) begin
                        // single BUSY cycle: no iterations, fixed divide-by-zero result
                        state     <= ST_DONE;
                        done      <= 1'b1;
                        div_zero  <= 1'b1;
                        result_lo <= WIDTH'(DIV0_QUOT);
                        result_hi <= acc[WIDTH-1:0];
                        rd_out    <= rd_q;
                    end else begin
                        acc   <= acc_nxt;
                        count <= count + 1'b1;
                        if (count == CNT_W'(WIDTH-1)) begin
                            state     <= ST_DONE;
                            done      <= 1'b1;
                            div_zero  <= 1'b0;
                            result_lo <= fin_lo;
                            result_hi <= fin_hi;
                            rd_out    <= rd_q;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_exec_muldiv_unit.sv
// Directed bench for exec_muldiv_unit: vector table plus flush/reset/back-to-back sequences.
// Expected values follow MULDIV_SIGNED_EN when it is defined for the build.
module tb_exec_muldiv_unit;
    import muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [15:0] rs_data = '0;
    logic [15:0] rd_data = '0;
    logic [2:0]  rd = '0;
    logic        flush = 1'b0;
    logic        stall;
    logic        done;
    logic [15:0] result_lo;
    logic [15:0] result_hi;
    logic [2:0]  rd_out;
    logic        div_zero;

    int n_cmp = 0;
    int n_bad = 0;

    exec_muldiv_unit #(.WIDTH(16), .CNT_W(5)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .rs_data(rs_data),
        .rd_data(rd_data), .rd(rd), .flush(flush), .stall(stall), .done(done),
        .result_lo(result_lo), .result_hi(result_hi), .rd_out(rd_out), .div_zero(div_zero)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [1:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [2:0]  r;
        logic [15:0] lo;
        logic [15:0] hi;
        logic        dz;
        int          lat;
    } vec_t;

    vec_t vt[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic issue(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b,
                         input logic [2:0] r);
        start = 1'b1; op = o; rs_data = a; rd_data = b; rd = r;
    endtask

    // Called in the start cycle; returns cycles to done (start cycle = 0) and stalled cycles.
    task automatic wait_done(output int lat, output int stalls);
        lat = -1;
        stalls = 0;
        #1;
        if (stall) stalls++;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); #1;
            start = 1'b0;
            #1;
            if (stall) stalls++;
            if (done) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic no_done_for(input int cycles, input string name);
        logic saw;
        saw = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk); #2;
            if (done) saw = 1'b1;
        end
        check(name, {31'd0, saw}, 32'd0);
    endtask

    initial begin
        int lat;
        int st;

        vt[0]  = '{OP_MULU, 16'h1234, 16'h0010, 3'd5, 16'h2340, 16'h0001, 1'b0, 17};
        vt[1]  = '{OP_DIVU, 16'd100,  16'd7,    3'd1, 16'd14,   16'd2,    1'b0, 17};
        vt[2]  = '{OP_DIVU, 16'h00AB, 16'h0000, 3'd2, 16'hFFFF, 16'h00AB, 1'b1, 2};
        vt[3]  = '{OP_MULU, 16'hFFFF, 16'hFFFF, 3'd7, 16'h0001, 16'hFFFE, 1'b0, 17};
        vt[4]  = '{OP_DIVU, 16'hFFFF, 16'h0001, 3'd3, 16'hFFFF, 16'h0000, 1'b0, 17};
        vt[5]  = '{OP_DIVU, 16'd5,    16'd9,    3'd4, 16'h0000, 16'h0005, 1'b0, 17};
        vt[6]  = '{OP_MULU, 16'h0000, 16'h1234, 3'd6, 16'h0000, 16'h0000, 1'b0, 17};
        vt[7]  = '{OP_DIVU, 16'hFFFF, 16'hFFFF, 3'd0, 16'h0001, 16'h0000, 1'b0, 17};
`ifdef MULDIV_SIGNED_EN
        vt[8]  = '{OP_DIVS, 16'hFFF9, 16'h0002, 3'd1, 16'hFFFD, 16'hFFFF, 1'b0, 17};
        vt[9]  = '{OP_MULS, 16'hFFFD, 16'h0005, 3'd2, 16'hFFF1, 16'hFFFF, 1'b0, 17};
        vt[10] = '{OP_DIVS, 16'h8000, 16'hFFFF, 3'd3, 16'h8000, 16'h0000, 1'b0, 17};
        vt[12] = '{OP_DIVS, 16'h0007, 16'hFFFE, 3'd5, 16'hFFFD, 16'h0001, 1'b0, 17};
`else
        vt[8]  = '{OP_DIVS, 16'hFFF9, 16'h0002, 3'd1, 16'h7FFC, 16'h0001, 1'b0, 17};
        vt[9]  = '{OP_MULS, 16'hFFFD, 16'h0005, 3'd2, 16'hFFF1, 16'h0004, 1'b0, 17};
        vt[10] = '{OP_DIVS, 16'h8000, 16'hFFFF, 3'd3, 16'h0000, 16'h8000, 1'b0, 17};
        vt[12] = '{OP_DIVS, 16'h0007, 16'hFFFE, 3'd5, 16'h0000, 16'h0007, 1'b0, 17};
`endif
        vt[11] = '{OP_DIVS, 16'h1234, 16'h0000, 3'd4, 16'hFFFF, 16'h1234, 1'b1, 2};

        // reset state
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("reset_outputs", {6'd0, done, div_zero, result_hi, result_lo} , 32'd0);
        check("reset_rd_stall", {28'd0, rd_out, stall}, 32'd0);

        // table: each op issued in the DONE cycle of the previous one
        foreach (vt[i]) begin
            issue(vt[i].op, vt[i].a, vt[i].b, vt[i].r);
            wait_done(lat, st);
            check($sformatf("v%0d latency", i), lat, vt[i].lat);
            check($sformatf("v%0d stall_cycles", i), st, vt[i].lat);
            check($sformatf("v%0d result_lo", i), {16'd0, result_lo}, {16'd0, vt[i].lo});
            check($sformatf("v%0d result_hi", i), {16'd0, result_hi}, {16'd0, vt[i].hi});
            check($sformatf("v%0d div_zero", i), {31'd0, div_zero}, {31'd0, vt[i].dz});
            check($sformatf("v%0d rd_out", i), {29'd0, rd_out}, {29'd0, vt[i].r});
        end

        // back-to-back: second op started in the DONE cycle of the first
        @(posedge clk); #1;
        issue(OP_DIVU, 16'd100, 16'd7, 3'd1);
        wait_done(lat, st);
        check("b2b_first_lo", {16'd0, result_lo}, 32'd14);
        issue(OP_MULU, 16'h0101, 16'h0003, 3'd3);
        wait_done(lat, st);
        check("b2b_second_latency", lat, 17);
        check("b2b_second_lo", {16'd0, result_lo}, 32'h0303);

        // flush at BUSY count 8
        issue(OP_MULU, 16'hFFFF, 16'hFFFF, 3'd6);
        @(posedge clk); #1 start = 1'b0;
        repeat (8) begin @(posedge clk); #1; end
        flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
        #1;
        check("flush_stall_drop", {31'd0, stall}, 32'd0);
        check("flush_results_held", {result_hi, result_lo}, 32'h0000_0303);
        check("flush_rd_held", {29'd0, rd_out}, 32'd3);
        no_done_for(20, "flush_no_done");

        // fresh op after flush, then done must be a single-cycle pulse
        issue(OP_MULU, 16'd3, 16'd4, 3'd4);
        wait_done(lat, st);
        check("post_flush_latency", lat, 17);
        check("post_flush_result", {result_hi, result_lo}, 32'd12);
        check("post_flush_rd", {29'd0, rd_out}, 32'd4);
        @(posedge clk); #2;
        check("done_one_cycle", {31'd0, done}, 32'd0);

        // flush together with start in IDLE drops the start
        @(posedge clk); #1;
        issue(OP_MULU, 16'd7, 16'd7, 3'd2);
        flush = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        flush = 1'b0;
        #1;
        check("idle_flush_start_stall", {31'd0, stall}, 32'd0);
        no_done_for(20, "idle_flush_start_no_done");
        check("idle_flush_results_held", {result_hi, result_lo}, 32'd12);

        // reset at BUSY count 5
        @(posedge clk); #1;
        issue(OP_MULU, 16'h1234, 16'h0010, 3'd5);
        @(posedge clk); #1 start = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #2;
        check("midreset_outputs", {6'd0, done, div_zero, result_hi, result_lo}, 32'd0);
        check("midreset_rd_stall", {28'd0, rd_out, stall}, 32'd0);
        #1 rst = 1'b0;
        no_done_for(20, "midreset_no_done");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
